hash_table_sched: RTL and testbench
===================================

HASH_TABLE_SCHED -- requirements
Module: hash_table_sched

Interface
REQ-001 SHALL have parameter SKETCH_SIZE, default 16, number of hashed k-mer values per sketch.
REQ-002 SHALL have parameter LOG2_NUM_OF_BUCKETS, default 8, bucket index width.
REQ-003 SHALL have parameter BUCKET_SIZE, default 16, maximum entries per bucket.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmdValid  input  1  command offered.
REQ-007 SHALL have port cmdReady  output  1  scheduler can accept a command.
REQ-008 SHALL have port cmdIsQuery  input  1  1 = query, 0 = insert.
REQ-009 SHALL have port cmdWindowID  input  32  window ID for insert; ignored for query.
REQ-010 SHALL have port hashedSketch  input  LOG2_NUM_OF_BUCKETS x SKETCH_SIZE (unpacked array)  bucket index per sketch element.
REQ-011 SHALL have port clearTable  input  1  request to empty all bucket length counters.
REQ-012 SHALL have port opValid  output  1  table operation presented.
REQ-013 SHALL have port opReady  input  1  hash table accepts operation.
REQ-014 SHALL have port opIsQuery  output  1  operation type.
REQ-015 SHALL have port opBucket  output  LOG2_NUM_OF_BUCKETS  target bucket.
REQ-016 SHALL have port opWindowID  output  32  window ID written on insert.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port doneIsQuery  output  1  type of completed command, valid with done.
REQ-019 SHALL have port doneDropped  output  $clog2(SKETCH_SIZE+1)  insert elements dropped (bucket full), valid with done.

Function
REQ-020 SHALL implement states IDLE, INSERT, QUERY, DONE.
REQ-021 cmdReady SHALL equal 1 exactly when state is IDLE and clearTable is 0.
REQ-022 IDLE: cmdValid&cmdReady SHALL latch cmdIsQuery, cmdWindowID, hashedSketch, clear element index to 0, clear drop counter, go to QUERY or INSERT.
REQ-023 IDLE: clearTable=1 SHALL zero all NUM_OF_BUCKETS (2^LOG2_NUM_OF_BUCKETS) length counters in that cycle; clearTable outside IDLE SHALL be ignored.
REQ-024 Scheduler SHALL keep one length counter per bucket, range 0..BUCKET_SIZE.
REQ-025 INSERT, element idx with bucket b: if len[b] < BUCKET_SIZE, opValid=1, opIsQuery=0, opBucket=b, opWindowID=latched ID; on opReady, len[b]++ and idx advances.
REQ-026 INSERT, len[b] == BUCKET_SIZE: opValid SHALL stay 0, drop counter increments, idx advances in one cycle regardless of opReady.
REQ-027 Repeated bucket within one sketch SHALL be handled per element; later elements see earlier increments.
REQ-028 QUERY: every element SHALL be issued with opValid=1, opIsQuery=1, opWindowID=0; idx advances on opReady; length counters unchanged.
REQ-029 While opValid=1 and opReady=0, opIsQuery, opBucket, opWindowID SHALL remain stable.
REQ-030 After element SKETCH_SIZE-1 completes (handshake or drop), state SHALL go to DONE.
REQ-031 DONE: done=1, doneIsQuery, doneDropped valid for exactly one cycle, then IDLE.
REQ-032 Latency with opReady=1, no drops: command accepted cycle T, ops T+1..T+SKETCH_SIZE, done T+SKETCH_SIZE+1, cmdReady T+SKETCH_SIZE+2.
REQ-033 cmdValid outside IDLE SHALL not be accepted; latched command values SHALL not change.
REQ-034 opValid, done SHALL be 0 in IDLE and DONE (done=1 only in DONE).

Reset
REQ-035 reset SHALL force state IDLE, all length counters 0, idx 0, drop counter 0, opValid 0, done 0, doneIsQuery 0, doneDropped 0, opBucket 0, opWindowID 0, opIsQuery 0.
REQ-036 reset SHALL take priority over every other input, including mid-INSERT/QUERY; the aborted command SHALL produce no done.

Verification
REQ-037 Reset, insert all-zero sketch, windowID 14, opReady=1 -> 16 ops bucket 0 ID 14 cycles T+1..T+16, done at T+17, doneDropped 0.
REQ-038 Repeat same insert -> no opValid, done at T+17, doneDropped 16.
REQ-039 Query all-zero sketch, opReady alternating 0/1 -> 16 handshakes, payload stable in stalls, done with doneIsQuery 1, doneDropped 0.
REQ-040 Sketch 8 elements bucket 3, 8 bucket 5, after bucket 3 preloaded with 12 entries -> 4 ops bucket 3 accepted, 4 dropped, 8 ops bucket 5, doneDropped 4.
REQ-041 clearTable in IDLE, then insert all-zero sketch -> cmdReady 0 during clear cycle, 16 ops issued, doneDropped 0.
REQ-042 reset asserted at element 5 of an insert -> next cycle opValid 0, cmdReady 1, no done; following insert to same buckets drops nothing.

Source files
------------

// File: rtl/hash_table_sched_if.sv
// Command, table-operation and completion signals of the hash table scheduler.
// The master side issues commands and accepts operations; the scheduler uses the slave side.
interface hash_table_sched_if #(
    parameter int SKETCH_SIZE         = 16,
    parameter int LOG2_NUM_OF_BUCKETS = 8
);
    localparam int DROP_W = $clog2(SKETCH_SIZE + 1);

    logic                           cmdValid;
    logic                           cmdReady;
    logic                           cmdIsQuery;
    logic [31:0]                    cmdWindowID;
    logic [LOG2_NUM_OF_BUCKETS-1:0] hashedSketch [SKETCH_SIZE];
    logic                           clearTable;

    logic                           opValid;
    logic                           opReady;
    logic                           opIsQuery;
    logic [LOG2_NUM_OF_BUCKETS-1:0] opBucket;
    logic [31:0]                    opWindowID;

    logic                           done;
    logic                           doneIsQuery;
    logic [DROP_W-1:0]              doneDropped;

    modport master (
        output cmdValid, cmdIsQuery, cmdWindowID, hashedSketch, clearTable, opReady,
        input  cmdReady, opValid, opIsQuery, opBucket, opWindowID,
               done, doneIsQuery, doneDropped
    );

    modport slave (
        input  cmdValid, cmdIsQuery, cmdWindowID, hashedSketch, clearTable, opReady,
        output cmdReady, opValid, opIsQuery, opBucket, opWindowID,
               done, doneIsQuery, doneDropped
    );
endinterface

// File: rtl/hash_table_sched.sv
// Walks a latched sketch element by element, issuing insert/query operations to a hash table
// and tracking per-bucket fill levels so inserts into full buckets are dropped and counted.
module hash_table_sched #(
    parameter int SKETCH_SIZE         = 16,
    parameter int LOG2_NUM_OF_BUCKETS = 8,
    parameter int BUCKET_SIZE         = 16
) (
    input logic             clk,
    input logic             reset,
    hash_table_sched_if.slave bus
);
    localparam int NUM_OF_BUCKETS = 1 << LOG2_NUM_OF_BUCKETS;
    localparam int LEN_W          = $clog2(BUCKET_SIZE + 1);
    localparam int IDX_W          = (SKETCH_SIZE > 1) ? $clog2(SKETCH_SIZE) : 1;
    localparam int DROP_W         = $clog2(SKETCH_SIZE + 1);

    typedef enum logic [1:0] {IDLE, INSERT, QUERY, DONE} state_t;

    state_t                         state_q, state_d;
    logic [LEN_W-1:0]               len_q [NUM_OF_BUCKETS];
    logic [IDX_W-1:0]               idx_q;
    logic [DROP_W-1:0]              drop_q;
    logic                           is_query_q;
    logic [31:0]                    window_id_q;
    logic [LOG2_NUM_OF_BUCKETS-1:0] sketch_q [SKETCH_SIZE];

    logic [LOG2_NUM_OF_BUCKETS-1:0] cur_bucket;
    logic                           bucket_full;
    logic                           last_elem;
    logic                           accept;
    logic                           advance;

    assign cur_bucket  = sketch_q[idx_q];
    assign bucket_full = (len_q[cur_bucket] == LEN_W'(BUCKET_SIZE));
    assign last_elem   = (idx_q == IDX_W'(SKETCH_SIZE - 1));

    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        advance          = 1'b0;
        bus.cmdReady     = 1'b0;
        bus.opValid      = 1'b0;
        bus.opIsQuery    = 1'b0;
        bus.opBucket     = '0;
        bus.opWindowID   = '0;
        bus.done         = 1'b0;
        bus.doneIsQuery  = 1'b0;
        bus.doneDropped  = '0;
        case (state_q)
            IDLE: begin
                bus.cmdReady = !bus.clearTable;
                accept       = bus.cmdValid && !bus.clearTable;
                if (accept) state_d = bus.cmdIsQuery ? QUERY : INSERT;
            end
            INSERT: begin
                // A full bucket is skipped in a single cycle without waiting for the table.
                bus.opValid    = !bucket_full;
                bus.opBucket   = cur_bucket;
                bus.opWindowID = window_id_q;
                advance        = bucket_full || bus.opReady;
                if (advance && last_elem) state_d = DONE;
            end
            QUERY: begin
                bus.opValid   = 1'b1;
                bus.opIsQuery = 1'b1;
                bus.opBucket  = cur_bucket;
                advance       = bus.opReady;
                if (advance && last_elem) state_d = DONE;
            end
            DONE: begin
                bus.done        = 1'b1;
                bus.doneIsQuery = is_query_q;
                bus.doneDropped = drop_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the length counters are architectural state and must read 0 after reset, so this
    // memory is reset explicitly; the latched sketch below is pure data and carries no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            drop_q      <= '0;
            is_query_q  <= 1'b0;
            window_id_q <= '0;
            for (int b = 0; b < NUM_OF_BUCKETS; b++) len_q[b] <= '0;
        end else begin
            if (accept) begin
                idx_q       <= '0;
                drop_q      <= '0;
                is_query_q  <= bus.cmdIsQuery;
                window_id_q <= bus.cmdWindowID;
            end else if (advance) begin
                idx_q <= last_elem ? '0 : idx_q + IDX_W'(1);
                if (state_q == INSERT && bucket_full) drop_q <= drop_q + DROP_W'(1);
            end

            if (state_q == IDLE && bus.clearTable) begin
                for (int b = 0; b < NUM_OF_BUCKETS; b++) len_q[b] <= '0;
            end else if (state_q == INSERT && !bucket_full && bus.opReady) begin
                len_q[cur_bucket] <= len_q[cur_bucket] + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) sketch_q <= bus.hashedSketch;
    end
endmodule

// File: tb/tb_hash_table_sched.sv
// Directed bench for hash_table_sched: insert, drop, stalled query, clear, partial drop and
// reset abort, each against hand-computed op counts, latencies and drop totals.
module tb_hash_table_sched;
    localparam int SK = 16;
    localparam int LB = 8;
    localparam int BS = 16;

    typedef logic [LB-1:0] sketch_t [SK];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hash_table_sched_if #(.SKETCH_SIZE(SK), .LOG2_NUM_OF_BUCKETS(LB)) bus ();

    hash_table_sched #(
        .SKETCH_SIZE(SK), .LOG2_NUM_OF_BUCKETS(LB), .BUCKET_SIZE(BS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [LB-1:0] op_q [$];
    int            first_op_cyc;
    int            done_cyc;
    logic          done_query;
    logic [4:0]    done_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one command, then runs it to completion while offering a conflicting command
    // and scrambled sketch; optionally pulses reset at cycle abort_c after acceptance.
    task automatic run_cmd(input logic q, input logic [31:0] id, input sketch_t sk,
                           input bit stall, input int abort_c);
        bit            have_prev;
        bit            seen_done;
        logic          prev_q;
        logic [LB-1:0] prev_b;
        logic [31:0]   prev_id;
        @(negedge clk);
        bus.cmdValid    = 1'b1;
        bus.cmdIsQuery  = q;
        bus.cmdWindowID = id;
        foreach (bus.hashedSketch[i]) bus.hashedSketch[i] = sk[i];
        bus.opReady     = 1'b1;
        #1;
        check("cmd_accept_ready", {31'd0, bus.cmdReady}, 32'd1);
        op_q.delete();
        first_op_cyc = 0;
        done_cyc     = 0;
        have_prev    = 1'b0;
        prev_q       = 1'b0;
        prev_b       = '0;
        prev_id      = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            bus.cmdValid    = 1'b1;
            bus.cmdIsQuery  = ~q;
            bus.cmdWindowID = 32'hDEAD_BEEF;
            foreach (bus.hashedSketch[i]) bus.hashedSketch[i] = 8'hEE;
            bus.opReady     = stall ? (c % 2 == 0) : 1'b1;
            if (c == abort_c) begin
                reset        = 1'b1;
                bus.cmdValid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                #1;
                check("abort_opvalid", {31'd0, bus.opValid}, 32'd0);
                check("abort_cmdready", {31'd0, bus.cmdReady}, 32'd1);
                seen_done = 1'b0;
                repeat (25) begin
                    @(negedge clk);
                    #1;
                    if (bus.done) seen_done = 1'b1;
                end
                check("abort_no_done", {31'd0, seen_done}, 32'd0);
                return;
            end
            #1;
            if (have_prev) begin
                check("stall_valid", {31'd0, bus.opValid}, 32'd1);
                check("stall_type", {31'd0, bus.opIsQuery}, {31'd0, prev_q});
                check("stall_bucket", {24'd0, bus.opBucket}, {24'd0, prev_b});
                check("stall_id", bus.opWindowID, prev_id);
            end
            have_prev = bus.opValid && !bus.opReady;
            prev_q    = bus.opIsQuery;
            prev_b    = bus.opBucket;
            prev_id   = bus.opWindowID;
            if (bus.opValid && bus.opReady) begin
                if (first_op_cyc == 0) first_op_cyc = c;
                op_q.push_back(bus.opBucket);
                check("op_type", {31'd0, bus.opIsQuery}, {31'd0, q});
                check("op_id", bus.opWindowID, q ? 32'd0 : id);
            end
            if (bus.done) begin
                done_cyc   = c;
                done_query = bus.doneIsQuery;
                done_drop  = bus.doneDropped;
                check("done_opvalid", {31'd0, bus.opValid}, 32'd0);
                bus.cmdValid = 1'b0;
                break;
            end
        end
        bus.cmdValid = 1'b0;
        check("done_seen", {31'd0, done_cyc != 0}, 32'd1);
        @(negedge clk);
        #1;
        check("post_done_ready", {31'd0, bus.cmdReady}, 32'd1);
        check("post_done_low", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic check_buckets(input string tag, input int split,
                                 input logic [LB-1:0] a, input logic [LB-1:0] b);
        int bad = 0;
        foreach (op_q[i]) if (op_q[i] !== ((i < split) ? a : b)) bad++;
        check(tag, bad, 32'd0);
    endtask

    sketch_t zero_sk, pre_sk, mix_sk, b20_sk;

    initial begin
        foreach (zero_sk[i]) zero_sk[i] = 8'd0;
        foreach (pre_sk[i])  pre_sk[i]  = (i < 12) ? 8'd3 : 8'd9;
        foreach (mix_sk[i])  mix_sk[i]  = (i < 8)  ? 8'd3 : 8'd5;
        foreach (b20_sk[i])  b20_sk[i]  = 8'd20;

        reset           = 1'b1;
        bus.cmdValid    = 1'b0;
        bus.cmdIsQuery  = 1'b0;
        bus.cmdWindowID = '0;
        bus.clearTable  = 1'b0;
        bus.opReady     = 1'b0;
        foreach (bus.hashedSketch[i]) bus.hashedSketch[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_opvalid", {31'd0, bus.opValid}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_cmdready", {31'd0, bus.cmdReady}, 32'd1);
        check("rst_opbucket", {24'd0, bus.opBucket}, 32'd0);
        check("rst_opid", bus.opWindowID, 32'd0);
        check("rst_optype", {31'd0, bus.opIsQuery}, 32'd0);
        check("rst_donedrop", {27'd0, bus.doneDropped}, 32'd0);
        check("rst_doneq", {31'd0, bus.doneIsQuery}, 32'd0);

        // Fresh insert of 16 elements into bucket 0.
        run_cmd(1'b0, 32'd14, zero_sk, 1'b0, 0);
        check("ins_ops", op_q.size(), 32'd16);
        check("ins_first_cyc", first_op_cyc, 32'd1);
        check("ins_done_cyc", done_cyc, 32'd17);
        check("ins_drop", {27'd0, done_drop}, 32'd0);
        check("ins_doneq", {31'd0, done_query}, 32'd0);
        check_buckets("ins_buckets", SK, 8'd0, 8'd0);

        // Same insert again: bucket 0 is full, everything drops at one element per cycle.
        run_cmd(1'b0, 32'd14, zero_sk, 1'b0, 0);
        check("full_ops", op_q.size(), 32'd0);
        check("full_done_cyc", done_cyc, 32'd17);
        check("full_drop", {27'd0, done_drop}, 32'd16);

        // Query with alternating opReady starting low: handshakes on even cycles 2..32.
        run_cmd(1'b1, 32'd99, zero_sk, 1'b1, 0);
        check("qry_ops", op_q.size(), 32'd16);
        check("qry_done_cyc", done_cyc, 32'd33);
        check("qry_doneq", {31'd0, done_query}, 32'd1);
        check("qry_drop", {27'd0, done_drop}, 32'd0);
        check_buckets("qry_buckets", SK, 8'd0, 8'd0);

        // Clear while a command is offered: not accepted, counters emptied.
        @(negedge clk);
        bus.clearTable = 1'b1;
        bus.cmdValid   = 1'b1;
        #1;
        check("clr_cmdready", {31'd0, bus.cmdReady}, 32'd0);
        @(negedge clk);
        bus.clearTable = 1'b0;
        bus.cmdValid   = 1'b0;
        #1;
        check("clr_still_idle", {31'd0, bus.opValid}, 32'd0);
        run_cmd(1'b0, 32'd5, zero_sk, 1'b0, 0);
        check("clr_ops", op_q.size(), 32'd16);
        check("clr_drop", {27'd0, done_drop}, 32'd0);

        // Preload bucket 3 with 12 entries, then 8x bucket 3 + 8x bucket 5: 4 accepted, 4 dropped.
        run_cmd(1'b0, 32'd1, pre_sk, 1'b0, 0);
        check("pre_drop", {27'd0, done_drop}, 32'd0);
        run_cmd(1'b0, 32'd2, mix_sk, 1'b0, 0);
        check("mix_ops", op_q.size(), 32'd12);
        check("mix_drop", {27'd0, done_drop}, 32'd4);
        check("mix_done_cyc", done_cyc, 32'd17);
        check_buckets("mix_buckets", 4, 8'd3, 8'd5);

        // Reset while element 5 is presented, then a full insert to the same bucket drops nothing.
        run_cmd(1'b0, 32'd3, b20_sk, 1'b0, 6);
        run_cmd(1'b0, 32'd4, b20_sk, 1'b0, 0);
        check("post_abort_ops", op_q.size(), 32'd16);
        check("post_abort_drop", {27'd0, done_drop}, 32'd0);
        check_buckets("post_abort_buckets", SK, 8'd20, 8'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
